// File: rtl/sc_isa_pkg.sv
// ============================================================================
// Module      : sc_isa_pkg
// Description : ISA tables shared by the single-cycle CPU decoder and the
//               instruction encoder: mnemonic codes, opcode/func constants,
//               field positions and word-packing helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sc_isa_pkg;

    // Mnemonic codes carried on the record stream. Codes 21..31 are unused
    // and are treated as illegal by the encoder.
    typedef enum logic [4:0] {
        MN_ADD  = 5'd0,
        MN_SUB  = 5'd1,
        MN_GT   = 5'd2,
        MN_AND  = 5'd3,
        MN_OR   = 5'd4,
        MN_XOR  = 5'd5,
        MN_SLL  = 5'd6,
        MN_SRL  = 5'd7,
        MN_SRA  = 5'd8,
        MN_JR   = 5'd9,
        MN_ADDI = 5'd10,
        MN_ANDI = 5'd11,
        MN_ORI  = 5'd12,
        MN_XORI = 5'd13,
        MN_LW   = 5'd14,
        MN_SW   = 5'd15,
        MN_BEQ  = 5'd16,
        MN_BNE  = 5'd17,
        MN_LUI  = 5'd18,
        MN_J    = 5'd19,
        MN_JAL  = 5'd20
    } mnem_e;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes
    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_SUB = 6'b100010;
    localparam logic [5:0] FUNC_GT  = 6'b100011;
    localparam logic [5:0] FUNC_AND = 6'b100100;
    localparam logic [5:0] FUNC_OR  = 6'b100101;
    localparam logic [5:0] FUNC_XOR = 6'b100110;
    localparam logic [5:0] FUNC_SLL = 6'b000000;
    localparam logic [5:0] FUNC_SRL = 6'b000010;
    localparam logic [5:0] FUNC_SRA = 6'b000011;
    localparam logic [5:0] FUNC_JR  = 6'b001000;

    // Field positions and widths within the 32-bit instruction word
    localparam int OP_LSB   = 26;
    localparam int OP_W     = 6;
    localparam int RS_LSB   = 21;
    localparam int RT_LSB   = 16;
    localparam int RD_LSB   = 11;
    localparam int SA_LSB   = 6;
    localparam int REG_W    = 5;
    localparam int FUNC_LSB = 0;
    localparam int FUNC_W   = 6;
    localparam int IMM_LSB  = 0;
    localparam int IMM_W    = 16;
    localparam int TGT_LSB  = 0;
    localparam int TGT_W    = 26;

    function automatic logic [31:0] pack_r(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [4:0] sa,
        input logic [5:0] func
    );
        logic [31:0] w;
        w = '0;
        w[OP_LSB   +: OP_W]   = OP_RTYPE;
        w[RS_LSB   +: REG_W]  = rs;
        w[RT_LSB   +: REG_W]  = rt;
        w[RD_LSB   +: REG_W]  = rd;
        w[SA_LSB   +: REG_W]  = sa;
        w[FUNC_LSB +: FUNC_W] = func;
        return w;
    endfunction

    function automatic logic [31:0] pack_i(
        input logic [5:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm16
    );
        logic [31:0] w;
        w = '0;
        w[OP_LSB  +: OP_W]  = op;
        w[RS_LSB  +: REG_W] = rs;
        w[RT_LSB  +: REG_W] = rt;
        w[IMM_LSB +: IMM_W] = imm16;
        return w;
    endfunction

    function automatic logic [31:0] pack_j(
        input logic [5:0]  op,
        input logic [25:0] target
    );
        logic [31:0] w;
        w = '0;
        w[OP_LSB  +: OP_W]  = op;
        w[TGT_LSB +: TGT_W] = target;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sc_inst_encoder_if.sv
// ============================================================================
// Module      : sc_inst_encoder_if
// Description : Symbolic instruction record stream (valid/ready handshake).
// Signals     : in_valid  - record valid (master -> slave)
//               in_ready  - record accepted when in_valid & in_ready
//               in_last   - final record of the program
//               in_mnem   - mnemonic code (sc_isa_pkg::mnem_e)
//               in_rs/in_rt/in_rd - register fields
//               in_imm    - sa=[4:0], imm16=[15:0], target=[25:0]
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sc_inst_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [4:0]  in_mnem;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [25:0] in_imm;

    modport master (
        output in_valid,
        output in_last,
        output in_mnem,
        output in_rs,
        output in_rt,
        output in_rd,
        output in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_last,
        input  in_mnem,
        input  in_rs,
        input  in_rt,
        input  in_rd,
        input  in_imm,
        output in_ready
    );

endinterface

`default_nettype wire

// File: rtl/sc_inst_pack.sv
// ============================================================================
// Module      : sc_inst_pack
// Description : Combinational packer: mnemonic + fields -> 32-bit MIPS word.
//               Fields an instruction does not use are forced to zero.
// Ports       : mnem    in  5   mnemonic code
//               rs/rt/rd in 5   register fields
//               imm     in  26  sa=[4:0], imm16=[15:0], target=[25:0]
//               word    out 32  encoded instruction (0 when illegal)
//               illegal out 1   mnemonic code not in the table
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_inst_pack
    import sc_isa_pkg::*;
(
    input  wire logic [4:0]  mnem,
    input  wire logic [4:0]  rs,
    input  wire logic [4:0]  rt,
    input  wire logic [4:0]  rd,
    input  wire logic [25:0] imm,
    output logic      [31:0] word,
    output logic             illegal
);

    logic [4:0]  w_sa;
    logic [15:0] w_imm16;

    assign w_sa    = imm[4:0];
    assign w_imm16 = imm[15:0];

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (mnem)
            MN_ADD:  word = pack_r(rs, rt, rd, 5'd0, FUNC_ADD);
            MN_SUB:  word = pack_r(rs, rt, rd, 5'd0, FUNC_SUB);
            MN_GT:   word = pack_r(rs, rt, rd, 5'd0, FUNC_GT);
            MN_AND:  word = pack_r(rs, rt, rd, 5'd0, FUNC_AND);
            MN_OR:   word = pack_r(rs, rt, rd, 5'd0, FUNC_OR);
            MN_XOR:  word = pack_r(rs, rt, rd, 5'd0, FUNC_XOR);
            // Shifts take their operand from rt; rs is not an input.
            MN_SLL:  word = pack_r(5'd0, rt, rd, w_sa, FUNC_SLL);
            MN_SRL:  word = pack_r(5'd0, rt, rd, w_sa, FUNC_SRL);
            MN_SRA:  word = pack_r(5'd0, rt, rd, w_sa, FUNC_SRA);
            MN_JR:   word = pack_r(rs, 5'd0, 5'd0, 5'd0, FUNC_JR);
            MN_ADDI: word = pack_i(OP_ADDI, rs, rt, w_imm16);
            MN_ANDI: word = pack_i(OP_ANDI, rs, rt, w_imm16);
            MN_ORI:  word = pack_i(OP_ORI,  rs, rt, w_imm16);
            MN_XORI: word = pack_i(OP_XORI, rs, rt, w_imm16);
            MN_LW:   word = pack_i(OP_LW,   rs, rt, w_imm16);
            MN_SW:   word = pack_i(OP_SW,   rs, rt, w_imm16);
            MN_BEQ:  word = pack_i(OP_BEQ,  rs, rt, w_imm16);
            MN_BNE:  word = pack_i(OP_BNE,  rs, rt, w_imm16);
            MN_LUI:  word = pack_i(OP_LUI, 5'd0, rt, w_imm16);
            MN_J:    word = pack_j(OP_J,   imm);
            MN_JAL:  word = pack_j(OP_JAL, imm);
            // Unknown code: emit a nop so later words keep their addresses.
            default: illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sc_inst_encoder.sv
// ============================================================================
// Module      : sc_inst_encoder
// Description : Streaming instruction encoder/loader. Accepts symbolic records,
//               packs each into a MIPS word and writes it to instruction memory
//               at consecutive addresses, holding the CPU in reset until the
//               program has been loaded.
// Ports       : clock      in   1         rising-edge clock
//               reset      in   1         synchronous, active-high
//               start      in   1         begin a new load (ignored in LOAD)
//               in_bus     slave          record stream
//               imem_we    out  1         instruction-memory write strobe
//               imem_addr  out  ADDR_W    write word address
//               imem_wdata out  32        encoded instruction
//               cpu_hold   out  1         1 = keep CPU in reset
//               done       out  1         load complete
//               bad_mnem   out  1         sticky: unknown mnemonic this load
//               overflow   out  1         sticky: memory full before in_last
//               word_count out  ADDR_W+1  words written this load
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_inst_encoder
    import sc_isa_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              start,
    sc_inst_encoder_if.slave       in_bus,
    output logic                   imem_we,
    output logic [ADDR_W-1:0]      imem_addr,
    output logic [31:0]            imem_wdata,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   bad_mnem,
    output logic                   overflow,
    output logic [ADDR_W:0]        word_count
);

    localparam logic [ADDR_W-1:0] c_base_addr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_last_addr = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             r_state;
    state_e             w_state_nxt;

    logic               r_stop_pending;  // last/final-address record taken
    logic [ADDR_W-1:0]  r_next_addr;     // address for the next accepted record
    logic               r_final;         // pending write ends the load
    logic               r_final_last;    // ...and it ended because of in_last
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic               r_done;
    logic               r_cpu_hold;
    logic               r_bad_mnem;
    logic               r_overflow;
    logic [ADDR_W:0]    r_word_count;

    logic               w_ready;
    logic               w_accept;
    logic               w_start_load;
    logic               w_at_end;
    logic [31:0]        w_word;
    logic               w_illegal;

    sc_inst_pack u_pack (
        .mnem    (in_bus.in_mnem),
        .rs      (in_bus.in_rs),
        .rt      (in_bus.in_rt),
        .rd      (in_bus.in_rd),
        .imm     (in_bus.in_imm),
        .word    (w_word),
        .illegal (w_illegal)
    );

    assign w_ready      = (r_state == ST_LOAD) && !r_stop_pending;
    assign w_accept     = in_bus.in_valid && w_ready;
    // start only matters outside LOAD, so it can never coincide with an accept.
    assign w_start_load = start && (r_state != ST_LOAD);
    assign w_at_end     = in_bus.in_last || (r_next_addr == c_last_addr);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_LOAD;
            ST_LOAD: if (r_we && r_final) w_state_nxt = ST_DONE;
            ST_DONE: if (start) w_state_nxt = ST_LOAD;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_stop_pending <= 1'b0;
            r_next_addr    <= c_base_addr;
            r_final        <= 1'b0;
            r_final_last   <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= c_base_addr;
            r_wdata        <= '0;
            r_done         <= 1'b0;
            r_cpu_hold     <= 1'b1;
            r_bad_mnem     <= 1'b0;
            r_overflow     <= 1'b0;
            r_word_count   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_we       <= w_accept;
            r_done     <= (w_state_nxt == ST_DONE);
            r_cpu_hold <= (w_state_nxt != ST_DONE);

            if (w_start_load) begin
                r_stop_pending <= 1'b0;
                r_next_addr    <= c_base_addr;
                r_addr         <= c_base_addr;
                r_final        <= 1'b0;
                r_final_last   <= 1'b0;
                r_bad_mnem     <= 1'b0;
                r_overflow     <= 1'b0;
                r_word_count   <= '0;
            end else begin
                if (w_accept) begin
                    r_addr       <= r_next_addr;
                    r_wdata      <= w_word;
                    r_next_addr  <= r_next_addr + 1'b1;
                    r_final      <= w_at_end;
                    r_final_last <= in_bus.in_last;
                    if (w_at_end) begin
                        r_stop_pending <= 1'b1;
                    end
                    if (w_illegal) begin
                        r_bad_mnem <= 1'b1;
                    end
                end
                if (r_we) begin
                    r_word_count <= r_word_count + 1'b1;
                    // Filling the last address without in_last is an overflow.
                    if (r_final && !r_final_last) begin
                        r_overflow <= 1'b1;
                    end
                end
            end
        end
    end

    assign in_bus.in_ready = w_ready;
    assign imem_we         = r_we;
    assign imem_addr       = r_addr;
    assign imem_wdata      = r_wdata;
    assign cpu_hold        = r_cpu_hold;
    assign done            = r_done;
    assign bad_mnem        = r_bad_mnem;
    assign overflow        = r_overflow;
    assign word_count      = r_word_count;

endmodule

`default_nettype wire

// File: tb/tb_sc_inst_encoder.sv
// ============================================================================
// Module      : tb_sc_inst_encoder
// Description : Directed self-checking bench for sc_inst_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sc_inst_encoder;
    import sc_isa_pkg::*;

    localparam int ADDR_W = 6;

    typedef struct {
        logic [4:0]  m;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [25:0] imm;
        logic        last;
    } rec_t;

    logic              clock;
    logic              reset;
    logic              start;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              bad_mnem;
    logic              overflow;
    logic [ADDR_W:0]   word_count;

    sc_inst_encoder_if bus ();

    sc_inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_bus     (bus),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .bad_mnem   (bad_mnem),
        .overflow   (overflow),
        .word_count (word_count)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    rec_t         recs[$];
    logic [31:0]  exp_words[$];
    int           wr_cyc[$];
    int           wr_addr[$];
    logic [31:0]  wr_data[$];
    int           acc_cyc[$];
    int           done_rise;
    logic         done_q;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Log writes, accepts and the first cycle done is seen high.
    always @(negedge clock) begin
        if (imem_we) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(int'(imem_addr));
            wr_data.push_back(imem_wdata);
        end
        if (bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
        if (done && !done_q && done_rise < 0) done_rise = cyc;
        done_q = done;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic add_rec(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [25:0] imm, input logic last,
                           input logic [31:0] exp);
        rec_t r;
        r.m = m; r.rs = rs; r.rt = rt; r.rd = rd; r.imm = imm; r.last = last;
        recs.push_back(r);
        exp_words.push_back(exp);
    endtask

    task automatic clear_logs();
        recs.delete(); exp_words.delete();
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); acc_cyc.delete();
        done_rise = -1;
    endtask

    // Called at posedge+1; holds valid high across records for back-to-back flow.
    task automatic send_all(input int wait_limit, output int n_acc);
        bit got;
        n_acc = 0;
        foreach (recs[i]) begin
            bus.in_valid = 1'b1;
            bus.in_mnem  = recs[i].m;
            bus.in_rs    = recs[i].rs;
            bus.in_rt    = recs[i].rt;
            bus.in_rd    = recs[i].rd;
            bus.in_imm   = recs[i].imm;
            bus.in_last  = recs[i].last;
            got = 1'b0;
            for (int w = 0; w < wait_limit && !got; w++) begin
                @(negedge clock);
                if (bus.in_ready) got = 1'b1;
            end
            if (!got) break;
            @(posedge clock); #1;
            n_acc++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        int n;
        check_eq({tag, " nwrites"}, 32'(wr_data.size()), 32'(exp_words.size()));
        n = (wr_data.size() < exp_words.size()) ? wr_data.size() : exp_words.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s word%0d", tag, i), wr_data[i], exp_words[i]);
            check_eq($sformatf("%s addr%0d", tag, i), 32'(wr_addr[i]), 32'(i));
            if (i < acc_cyc.size())
                check_eq($sformatf("%s lat%0d", tag, i), 32'(wr_cyc[i]), 32'(acc_cyc[i] + 1));
            if (i > 0)
                check_eq($sformatf("%s b2b%0d", tag, i), 32'(wr_cyc[i]), 32'(wr_cyc[i-1] + 1));
        end
        if (n > 0)
            check_eq({tag, " done_lat"}, 32'(done_rise), 32'(wr_cyc[n-1] + 1));
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, " we"},    32'(imem_we),    32'd0);
        check_eq({tag, " addr"},  32'(imem_addr),  32'd0);
        check_eq({tag, " wdata"}, imem_wdata,      32'd0);
        check_eq({tag, " hold"},  32'(cpu_hold),   32'd1);
        check_eq({tag, " done"},  32'(done),       32'd0);
        check_eq({tag, " bad"},   32'(bad_mnem),   32'd0);
        check_eq({tag, " ovf"},   32'(overflow),   32'd0);
        check_eq({tag, " count"}, 32'(word_count), 32'd0);
        check_eq({tag, " ready"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic check_status(input string tag, input int cnt, input logic bad,
                                input logic ovf);
        check_eq({tag, " done"},  32'(done),       32'd1);
        check_eq({tag, " hold"},  32'(cpu_hold),   32'd0);
        check_eq({tag, " count"}, 32'(word_count), 32'(cnt));
        check_eq({tag, " bad"},   32'(bad_mnem),   32'(bad));
        check_eq({tag, " ovf"},   32'(overflow),   32'(ovf));
        check_eq({tag, " ready"}, 32'(bus.in_ready), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_acc;
        done_q       = 1'b0;
        done_rise    = -1;
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_mnem  = '0;
        bus.in_rs    = '0;
        bus.in_rt    = '0;
        bus.in_rd    = '0;
        bus.in_imm   = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_vals("reset");
        @(posedge clock); #1;
        reset = 1'b0;

        // Load 1: mixed encodings with ignored fields populated, unknown mnemonic last.
        clear_logs();
        add_rec(MN_ADD, 5'd1,  5'd2, 5'd3, 26'h1F,    1'b0, 32'h00221820);
        add_rec(MN_GT,  5'd1,  5'd2, 5'd3, 26'h0,     1'b0, 32'h00221823);
        add_rec(MN_LW,  5'd5,  5'd4, 5'd9, 26'h8,     1'b0, 32'h8CA40008);
        add_rec(MN_BEQ, 5'd1,  5'd2, 5'd0, 26'hFFFF,  1'b0, 32'h1022FFFF);
        add_rec(MN_SLL, 5'd7,  5'd3, 5'd2, 26'h4,     1'b0, 32'h00031100);
        add_rec(MN_J,   5'd3,  5'd4, 5'd5, 26'h40,    1'b0, 32'h08000040);
        add_rec(MN_JAL, 5'd0,  5'd0, 5'd0, 26'h10,    1'b0, 32'h0C000010);
        add_rec(MN_JR,  5'd31, 5'd7, 5'd5, 26'h3,     1'b0, 32'h03E00008);
        add_rec(5'd31,  5'd1,  5'd2, 5'd3, 26'h1234,  1'b1, 32'h00000000);
        pulse_start();
        send_all(10, n_acc);
        check_eq("l1 accepted", 32'(n_acc), 32'd9);
        @(negedge clock);
        check_eq("l1 ready_after_last", 32'(bus.in_ready), 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_writes("l1");
        check_status("l1", 9, 1'b1, 1'b0);

        // Load 2: three back-to-back records, restarted from DONE.
        @(posedge clock); #1;
        clear_logs();
        add_rec(MN_ADD, 5'd4, 5'd5, 5'd6, 26'h0, 1'b0, 32'h00853020);
        add_rec(MN_SUB, 5'd4, 5'd5, 5'd6, 26'h0, 1'b0, 32'h00853022);
        add_rec(MN_OR,  5'd4, 5'd5, 5'd6, 26'h0, 1'b1, 32'h00853025);
        pulse_start();
        send_all(10, n_acc);
        check_eq("l2 accepted", 32'(n_acc), 32'd3);
        @(negedge clock);
        check_eq("l2 ready_after_last", 32'(bus.in_ready), 32'd0);
        check_eq("l2 hold_during_write", 32'(cpu_hold), 32'd1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_writes("l2");
        check_status("l2", 3, 1'b0, 1'b0);

        // Load 3: remaining table entries; start held high throughout the load.
        @(posedge clock); #1;
        clear_logs();
        add_rec(MN_ADDI, 5'd2, 5'd3, 5'd4, 26'h1234, 1'b0, 32'h20431234);
        add_rec(MN_ANDI, 5'd2, 5'd3, 5'd4, 26'h1234, 1'b0, 32'h30431234);
        add_rec(MN_ORI,  5'd2, 5'd3, 5'd4, 26'h1234, 1'b0, 32'h34431234);
        add_rec(MN_XORI, 5'd2, 5'd3, 5'd4, 26'h1234, 1'b0, 32'h38431234);
        add_rec(MN_SW,   5'd2, 5'd3, 5'd4, 26'h1234, 1'b0, 32'hAC431234);
        add_rec(MN_BNE,  5'd2, 5'd3, 5'd4, 26'h1234, 1'b0, 32'h14431234);
        add_rec(MN_LUI,  5'd2, 5'd3, 5'd4, 26'h1234, 1'b0, 32'h3C031234);
        add_rec(MN_AND,  5'd2, 5'd3, 5'd4, 26'h5,    1'b0, 32'h00432024);
        add_rec(MN_XOR,  5'd2, 5'd3, 5'd4, 26'h0,    1'b0, 32'h00432026);
        add_rec(MN_SRL,  5'd2, 5'd3, 5'd4, 26'h5,    1'b0, 32'h00032142);
        add_rec(MN_SRA,  5'd2, 5'd3, 5'd4, 26'h5,    1'b1, 32'h00032143);
        start = 1'b1;
        @(posedge clock); #1;
        send_all(10, n_acc);
        start = 1'b0;
        check_eq("l3 accepted", 32'(n_acc), 32'd11);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_writes("l3");
        check_status("l3", 11, 1'b0, 1'b0);

        // Load 4: 65 records, no last -> memory fills, 65th never taken.
        @(posedge clock); #1;
        clear_logs();
        for (int i = 0; i < 65; i++)
            add_rec(MN_ADD, 5'd1, 5'd2, 5'd3, 26'h0, 1'b0, 32'h00221820);
        pulse_start();
        send_all(10, n_acc);
        check_eq("ovf accepted", 32'(n_acc), 32'd64);
        check_eq("ovf nwrites", 32'(wr_data.size()), 32'd64);
        if (wr_addr.size() == 64) begin
            check_eq("ovf last_addr", 32'(wr_addr[63]), 32'd63);
            check_eq("ovf done_lat", 32'(done_rise), 32'(wr_cyc[63] + 1));
        end
        check_status("ovf", 64, 1'b0, 1'b1);

        // Load 5: reset asserted mid-stream, then a fresh load from base.
        @(posedge clock); #1;
        clear_logs();
        pulse_start();
        bus.in_valid = 1'b1;
        bus.in_mnem  = MN_SUB;
        bus.in_rs    = 5'd4;
        bus.in_rt    = 5'd5;
        bus.in_rd    = 5'd6;
        bus.in_imm   = '0;
        bus.in_last  = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check_eq("mid count_before", 32'(word_count), 32'd3);
        reset = 1'b1;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        @(negedge clock);
        check_reset_vals("mid reset");
        @(posedge clock); #1;
        reset = 1'b0;
        clear_logs();
        add_rec(MN_ADD, 5'd1, 5'd2, 5'd3, 26'h0, 1'b1, 32'h00221820);
        pulse_start();
        send_all(10, n_acc);
        check_eq("restart accepted", 32'(n_acc), 32'd1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_writes("restart");
        check_status("restart", 1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
